sys_bus_sequencer: RTL

//  Registered, multi-cycle successor to the combinational CPU-side bus driver. Arbitrates four

---
 rtl/sys_bus_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sys_bus_sequencer.sv
// Multi-cycle CPU-side bus sequencer: four-way fixed-priority arbitration, one transaction at a
// time with programmable plus memory-extended wait states, byte/word formatting and one-hot ack.
module sys_bus_sequencer #(
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [AW-1:0] int_addr,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] data_addr,
    input  logic          data_we,
    input  logic          data_bw,
    input  logic [DW-1:0] data_wdata,
    input  logic          mem_wait,
    input  logic [DW-1:0] MDBin,
    output logic [AW-1:0] MAB,
    output logic [DW-1:0] MDBout,
    output logic          BW,
    output logic          MW,
    output logic [3:0]    ack,
    output logic [DW-1:0] rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    state_t        state_q, state_d;
    logic          load;
    logic [1:0]    sel;
    logic [1:0]    grant_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic          bw_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    cnt_q;
    logic          in_access;
    logic          finish;

    // Fixed priority: lowest set request bit wins.
    always_comb begin
        sel = 2'd0;
        if (req[0])      sel = 2'd0;
        else if (req[1]) sel = 2'd1;
        else if (req[2]) sel = 2'd2;
        else if (req[3]) sel = 2'd3;
    end

    assign finish = (state_q == ACCESS) && (cnt_q == 4'd0) && !mem_wait;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 4'b0) begin
                    state_d = ACCESS;
                    load    = 1'b1;
                end
            end
            ACCESS: begin
                if (finish) state_d = DONE;
            end
            DONE: begin
                if (req != 4'b0) begin
                    state_d = ACCESS;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            bw_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= 4'd0;
            rdata   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                grant_q <= sel;
                cnt_q   <= WS_INIT;
                case (sel)
                    2'd0: begin
                        addr_q  <= int_addr;
                        we_q    <= 1'b0;
                        bw_q    <= 1'b0;
                        wdata_q <= '0;
                    end
                    2'd1, 2'd2: begin
                        addr_q  <= pc;
                        we_q    <= 1'b0;
                        bw_q    <= 1'b0;
                        wdata_q <= '0;
                    end
                    default: begin
                        addr_q  <= data_addr;
                        we_q    <= data_we;
                        bw_q    <= data_bw;
                        wdata_q <= data_wdata;
                    end
                endcase
            end else if (state_q == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (finish) begin
                if (we_q)      rdata <= '0;
                else if (bw_q) rdata <= {{(DW-8){1'b0}}, MDBin[7:0]};
                else           rdata <= MDBin;
            end
        end
    end

    // Bus is driven only in ACCESS, so reset forces MW low without waiting for a clock.
    assign in_access = (state_q == ACCESS);
    assign busy      = in_access;
    assign BW        = in_access && bw_q;
    assign MW        = in_access && we_q;
    assign MAB       = !in_access ? '0 : (bw_q ? addr_q : {addr_q[AW-1:1], 1'b0});
    assign MDBout    = !(in_access && we_q) ? '0
                     : (bw_q ? {{(DW-8){1'b0}}, wdata_q[7:0]} : wdata_q);
    assign ack       = (state_q == DONE) ? (4'b0001 << grant_q) : 4'b0000;

endmodule
